// File: rtl/conv_pkg.sv
// Shared types for the column multicaster: FSM states, the buffered bus word
// and stream-enable bit positions.
package conv_pkg;

  localparam int MC_DW    = 16;
  localparam int EN_IFMAP = 0;
  localparam int EN_FLTR  = 1;
  localparam int EN_PSUM  = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_PSUM,
    DRAIN
  } mc_state_e;

  typedef struct packed {
    logic [2:0]         en;
    logic [MC_DW-1:0]   ifmap;
    logic [MC_DW-1:0]   fltr;
    logic [2*MC_DW-1:0] psum;
  } mc_word_t;

  // A zero-length window is treated as a single-word window.
  function automatic logic [7:0] mc_ksize_norm(input logic [7:0] k);
    return (k == 8'd0) ? 8'd1 : k;
  endfunction

endpackage

// File: rtl/mc_sync_fifo.sv
// Registered synchronous FIFO; the head is always presented on o_rd_data
// and a pushed word becomes visible the cycle after the push.
module mc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop && !o_empty) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/mcast_pe_feeder.sv
// Column multicaster: filters bus words by tag, buffers them for one PE,
// counts one kernel window per pass and returns the finished psum to the bus.
module mcast_pe_feeder
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = MC_DW,
  parameter int NUM_COL    = 4,
  parameter int FIFO_DEPTH = 2,
  localparam int ID_W = $clog2(NUM_COL)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_W-1:0]         cfg_id,
  input  logic                    bus_valid,
  output logic                    bus_ready,
  input  logic [ID_W-1:0]         bus_tag,
  input  logic [2:0]              bus_en,
  input  logic [DATA_WIDTH-1:0]   bus_ifmap,
  input  logic [DATA_WIDTH-1:0]   bus_fltr,
  input  logic [2*DATA_WIDTH-1:0] bus_psum,
  input  logic [7:0]              bus_ksize,
  output logic                    pe_valid,
  input  logic                    pe_ready,
  output logic [2:0]              pe_en,
  output logic [DATA_WIDTH-1:0]   pe_ifmap,
  output logic [DATA_WIDTH-1:0]   pe_fltr,
  output logic [2*DATA_WIDTH-1:0] pe_psum,
  input  logic                    pe_osum_valid,
  output logic                    pe_osum_ready,
  input  logic [2*DATA_WIDTH-1:0] pe_osum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_psum,
  output logic                    busy
);

  localparam int WORD_W = $bits(mc_word_t);

  mc_state_e r_state;
  mc_state_e w_state_nxt;
  logic [7:0] r_count;
  logic [7:0] r_ksize;
  logic [7:0] r_last_ksize;
  logic       r_out_valid;
  logic [2*DATA_WIDTH-1:0] r_out_psum;

  mc_word_t   w_wr_word;
  mc_word_t   w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_match;
  logic       w_push;
  logic       w_pop;
  logic       w_osum_hs;
  logic       w_count_en;
  logic       w_start;
  logic [7:0] w_ksize_in;
  logic [7:0] w_start_ksize;

  assign w_match    = (bus_tag == cfg_id) && (bus_en != 3'b000);
  // Full blocks a matching word even if the PE pops this cycle.
  assign bus_ready  = !w_match || !w_full;
  assign w_push     = bus_valid && w_match && !w_full;
  assign w_wr_word  = '{en: bus_en, ifmap: bus_ifmap, fltr: bus_fltr, psum: bus_psum};
  assign w_ksize_in = mc_ksize_norm(bus_ksize);

  assign pe_valid   = !w_empty && (r_state == RUN);
  assign w_pop      = pe_valid && pe_ready;
  assign w_count_en = w_pop && w_head.en[EN_IFMAP];
  assign pe_en      = {w_head.en[EN_PSUM], w_head.en[EN_FLTR], w_head.en[EN_IFMAP]};
  assign pe_ifmap   = w_head.ifmap;
  assign pe_fltr    = w_head.fltr;
  assign pe_psum    = w_head.psum;

  assign pe_osum_ready = (r_state == WAIT_PSUM) && !r_out_valid;
  assign w_osum_hs     = pe_osum_valid && pe_osum_ready;
  assign out_valid     = r_out_valid;
  assign out_psum      = r_out_psum;
  assign busy          = (r_state != IDLE);

  mc_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_wr_data (w_wr_word),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_start_ksize = w_ksize_in;
    case (r_state)
      IDLE: begin
        if (w_push) begin
          w_state_nxt = RUN;
          w_start     = 1'b1;
        end
      end
      RUN: begin
        if (w_count_en && (r_count == r_ksize - 8'd1)) w_state_nxt = WAIT_PSUM;
      end
      WAIT_PSUM: begin
        if (w_osum_hs) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Words queued during the previous window start the next one directly.
        if (r_out_valid && out_ready) begin
          if (!w_empty || w_push) begin
            w_state_nxt   = RUN;
            w_start       = 1'b1;
            w_start_ksize = w_push ? w_ksize_in : r_last_ksize;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_ksize      <= 8'd1;
      r_last_ksize <= 8'd1;
    end else begin
      if (w_push) r_last_ksize <= w_ksize_in;
      if (w_start) begin
        r_count <= '0;
        r_ksize <= w_start_ksize;
      end else if ((r_state == RUN) && w_count_en) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_psum  <= '0;
    end else if (w_osum_hs) begin
      r_out_valid <= 1'b1;
      r_out_psum  <= pe_osum;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
